// File: rtl/serial_add_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the supported operand-width range.
package serial_add_sub_ctrl_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_fa_bit.sv
// Single combinational full-adder cell, shared across all bit positions
// by the serial controller.
module serial_fa_bit (
   output logic S,
   output logic Cout,
   input  logic A,
   input  logic B,
   input  logic Cin
);

   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial N-bit adder/subtractor: streams operands LSB first through one
// full-adder cell, WIDTH cycles per operation, with a start/done handshake.
module serial_add_sub_ctrl
   import serial_add_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_add_sub_ctrl: WIDTH out of supported range");
   end

   state_t             state_reg;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   opa_reg;
   logic [WIDTH-1:0]   opb_reg;
   logic [WIDTH-1:0]   acc_reg;
   logic [WIDTH-1:0]   acc_next;
   logic               carry_reg;
   logic               cmsb_reg;
   logic [WIDTH-1:0]   result_reg;
   logic               cout_reg;
   logic               ovf_reg;
   logic               fa_s;
   logic               fa_cout;
   logic               accept;
   logic               last_bit;

   serial_fa_bit u_fa (
      .S    (fa_s),
      .Cout (fa_cout),
      .A    (opa_reg[0]),
      .B    (opb_reg[0]),
      .Cin  (carry_reg)
   );

   // A new request is only taken when no operation is in flight.
   assign accept   = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
   assign last_bit = (cnt_reg == CNT_LAST);
   assign acc_next = {fa_s, acc_reg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (last_bit) state_next = ST_DONE;
         ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         opa_reg    <= '0;
         opb_reg    <= '0;
         acc_reg    <= '0;
         carry_reg  <= 1'b0;
         cmsb_reg   <= 1'b0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else if (accept) begin
         opa_reg   <= a;
         opb_reg   <= sub ? ~b : b;
         carry_reg <= sub;
         cnt_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
         carry_reg <= fa_cout;
         opa_reg   <= opa_reg >> 1;
         opb_reg   <= opb_reg >> 1;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_reg + 1'b1;
         // Carry produced by bit WIDTH-2 is the carry into the MSB.
         if (cnt_reg == CNT_PRE) begin
            cmsb_reg <= fa_cout;
         end
         if (last_bit) begin
            result_reg <= acc_next;
            cout_reg   <= fa_cout;
            ovf_reg    <= cmsb_reg ^ fa_cout;
         end
      end
   end

   assign result   = result_reg;
   assign cout     = cout_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Self-checking bench for serial_add_sub_ctrl at WIDTH=8: table vectors,
// handshake corner sequences and randomized operations vs. an arithmetic model.
module tb_serial_add_sub_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   serial_add_sub_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vsub;
      logic [W-1:0] er;
      logic         ec;
      logic         ev;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed overflow from range test.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v);
      int sx, sy, sr;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (s) begin
         r  = W'(int'(x) - int'(y));
         c  = (x >= y);
         sr = sx - sy;
      end else begin
         r  = W'(int'(x) + int'(y));
         c  = (int'(x) + int'(y)) > 255;
         sr = sx + sy;
      end
      v = (sr > 127) || (sr < -128);
   endfunction

   // Issue one op, wait for done; returns edges from accept to done and busy cycles.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        output int lat, output int busy_cnt);
      @(negedge clk);
      a = ta; b = tb; sub = ts; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL op_timeout: done never rose for a=%0h b=%0h sub=%0b", ta, tb, ts);
      end
   endtask

   vec_t vecs[8];

   initial begin
      int lat, bcnt, ndone, first_at, second_at, cyc;
      logic [W-1:0] er, held;
      logic ec, ev, held_ok;

      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, lat, bcnt);
         $display("vec %0d: a=%h b=%h sub=%0b -> result=%h cout=%0b ovf=%0b lat=%0d busy=%0d",
                  i, vecs[i].va, vecs[i].vb, vecs[i].vsub, result, cout, overflow, lat, bcnt);
         check("vec_result", 32'(result), 32'(vecs[i].er));
         check("vec_cout", 32'(cout), 32'(vecs[i].ec));
         check("vec_ovf", 32'(overflow), 32'(vecs[i].ev));
         check("vec_latency", 32'(lat), 32'(W));
         check("vec_busy_cycles", 32'(bcnt), 32'(W));
         check("vec_busy_with_done", 32'(busy), 32'd0);
         @(posedge clk); #1;
         check("done_single_pulse", 32'(done), 32'd0);
      end

      // Start pulse in mid-RUN must be ignored.
      @(negedge clk);
      a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      held = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            held = result;
         end
      end
      $display("ignore-start: done pulses=%0d result=%h", ndone, held);
      check("ignore_start_pulses", 32'(ndone), 32'd1);
      check("ignore_start_result", 32'(held), 32'h7F);

      // Back-to-back: start held high through DONE.
      @(negedge clk);
      a = 8'h10; b = 8'h20; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      a = 8'h35; b = 8'h4A; sub = 1'b0;
      first_at = -1; second_at = -1; held_ok = 1'b1; held = '0;
      cyc = 0;
      while (second_at < 0 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done && first_at < 0) begin
            first_at = cyc;
            held = result;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            check("b2b_no_idle", 32'(busy), 32'd1);
         end else if (done) begin
            second_at = cyc;
         end else if (first_at >= 0 && result !== held) begin
            held_ok = 1'b0;
         end
      end
      $display("back-to-back: done at %0d and %0d, op1=%h op2=%h", first_at, second_at, held, result);
      check("b2b_first_result", 32'(held), 32'hF0);
      check("b2b_gap", 32'(second_at - first_at), 32'(W + 1));
      check("b2b_result_held", 32'(held_ok), 32'd1);
      check("b2b_second_result", 32'(result), 32'h7F);

      // Reset mid-RUN aborts the operation.
      @(negedge clk);
      a = 8'hFF; b = 8'h01; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      $display("abort: activity cycles after reset=%0d", ndone);
      check("abort_no_done", 32'(ndone), 32'd0);
      do_op(8'h10, 8'h20, 1'b1, lat, bcnt);
      $display("post-reset op: result=%h cout=%0b ovf=%0b", result, cout, overflow);
      check("post_reset_result", 32'(result), 32'hF0);
      check("post_reset_cout", 32'(cout), 32'd0);

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic rs;
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, er, ec, ev);
         do_op(ra, rb, rs, lat, bcnt);
         $display("rand %0d: a=%h b=%h sub=%0b -> result=%h cout=%0b ovf=%0b (model %h %0b %0b)",
                  i, ra, rb, rs, result, cout, overflow, er, ec, ev);
         check("rand_result", 32'(result), 32'(er));
         check("rand_cout", 32'(cout), 32'(ec));
         check("rand_ovf", 32'(overflow), 32'(ev));
         check("rand_latency", 32'(lat), 32'(W));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
